// File: rtl/uart_pattern_tx_pkg.sv
// uart_pattern_tx_pkg
//   Shared definitions for the UART pattern transmitter and the IO-decode
//   trigger's UART receiver: FSM state type, slot count default, the 8x
//   oversample constant and the baud accumulator increment width.
//   Optional macro UART_PATTERN_TX_GAP_EN enables the inter-byte GAP state.
package uart_pattern_tx_pkg;

  localparam int unsigned NBYTES_DEF = 8;
  localparam int unsigned OVERSAMPLE = 8;
  localparam int unsigned OS_W       = $clog2(OVERSAMPLE);
  localparam int unsigned UART_INC_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_NEXT   = 3'd6,
    ST_GAP    = 3'd7
  } tx_state_e;

  // Even parity: bit that makes the total count of ones even.
  function automatic logic tx_parity(input logic [7:0] b, input logic even);
    return even ? (^b) : ~(^b);
  endfunction

endpackage

// File: rtl/uart_pattern_tx_if.sv
// uart_pattern_tx_if
//   Control handshake between the register block and uart_pattern_tx.
//   start/abort : single-cycle requests (master -> slave)
//   busy        : pattern in progress
//   byte_sent   : one-cycle pulse after each byte's final stop bit
//   done        : one-cycle pulse on normal pattern completion
interface uart_pattern_tx_if;
  logic start;
  logic abort;
  logic busy;
  logic byte_sent;
  logic done;

  modport master (output start, output abort,
                  input  busy, input byte_sent, input done);
  modport slave  (input  start, input abort,
                  output busy, output byte_sent, output done);
endinterface

// File: rtl/uart_pattern_tx_baud_tick.sv
// uart_baud_tick
//   Fractional baud accumulator producing one oversample tick per carry.
//   clk      : system clock
//   reset_i  : synchronous active-low reset
//   clr      : synchronous phase clear
//   baud_inc : accumulator increment (0 = no ticks)
//   tick     : carry bit of the accumulator
module uart_baud_tick
  import uart_pattern_tx_pkg::*;
#(
  parameter int unsigned INC_W = UART_INC_W
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             clr,
  input  logic [INC_W-1:0] baud_inc,
  output logic             tick
);

  logic [INC_W:0] acc;

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      acc <= '0;
    end else if (clr) begin
      // Phase is cleared but this cycle's increment still lands, so the
      // first bit after a start lasts exactly OVERSAMPLE ticks.
      acc <= {1'b0, baud_inc};
    end else begin
      acc <= {1'b0, acc[INC_W-1:0]} + {1'b0, baud_inc};
    end
  end

  assign tick = acc[INC_W];

endmodule

// File: rtl/uart_pattern_tx.sv
// uart_pattern_tx
//   Register-programmed UART transmitter sending the masked subset of up to
//   NBYTES pattern bytes (lowest slot first) on txd.
//   clk, reset_i       : clock, synchronous active-low reset
//   baud_inc           : baud accumulator increment (8 ticks per bit)
//   tx_data, byte_mask : pattern bytes (byte 0 = [7:0]) and slot enables
//   parity_en/_even    : optional parity bit, even or odd
//   two_stopbits       : two stop bits instead of one
//   ctl (slave)        : start/abort requests, busy/byte_sent/done status
//   txd                : serial output, idle high
//   gap_bits           : idle bit periods between bytes, only when
//                        UART_PATTERN_TX_GAP_EN is defined
module uart_pattern_tx
  import uart_pattern_tx_pkg::*;
#(
  parameter int unsigned NBYTES = NBYTES_DEF,
  parameter int unsigned INC_W  = UART_INC_W
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic [INC_W-1:0]    baud_inc,
  input  logic [8*NBYTES-1:0] tx_data,
  input  logic [NBYTES-1:0]   byte_mask,
  input  logic                parity_en,
  input  logic                parity_even,
  input  logic                two_stopbits,
`ifdef UART_PATTERN_TX_GAP_EN
  input  logic [3:0]          gap_bits,
`endif
  uart_pattern_tx_if.slave    ctl,
  output logic                txd
);

  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  tx_state_e           state;
  logic                tick;
  logic                bit_end;
  logic                start_ok;
  logic [OS_W-1:0]     tick_cnt;
  logic [2:0]          bit_cnt;
  logic [7:0]          shreg;
  logic                par_q;
  logic [NBYTES-1:0]   pend_q;
  logic [8*NBYTES-1:0] data_q;
  logic                pen_q, peven_q, two_q;
  logic                txd_q, busy_q, bs_q, done_q;
`ifdef UART_PATTERN_TX_GAP_EN
  logic [3:0]          gap_q, gap_cnt;
`endif

  logic [NBYTES-1:0]   mask_src, sel_oh;
  logic [8*NBYTES-1:0] data_src;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_found, even_src, sel_par;
  logic [7:0]          sel_byte;

  assign start_ok = (state == ST_IDLE) && ctl.start && !ctl.abort;
  assign bit_end  = tick && (tick_cnt == OS_W'(OVERSAMPLE - 1));

  uart_baud_tick #(.INC_W(INC_W)) u_tick (
    .clk      (clk),
    .reset_i  (reset_i),
    .clr      (start_ok),
    .baud_inc (baud_inc),
    .tick     (tick)
  );

  // One scanner serves both the first byte (live inputs, in IDLE) and every
  // following byte (latched copies, in NEXT); pend_q holds unsent slots.
  always_comb begin
    mask_src  = (state == ST_IDLE) ? byte_mask   : pend_q;
    data_src  = (state == ST_IDLE) ? tx_data     : data_q;
    even_src  = (state == ST_IDLE) ? parity_even : peven_q;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_oh    = '0;
    for (int unsigned i = NBYTES; i > 0; i--) begin
      if (mask_src[i-1]) begin
        sel_found   = 1'b1;
        sel_idx     = IDX_W'(i - 1);
        sel_oh      = '0;
        sel_oh[i-1] = 1'b1;
      end
    end
    sel_byte = data_src[{sel_idx, 3'b000} +: 8];
    sel_par  = tx_parity(sel_byte, even_src);
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      pend_q   <= '0;
      data_q   <= '0;
      pen_q    <= 1'b0;
      peven_q  <= 1'b0;
      two_q    <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      bs_q     <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_PATTERN_TX_GAP_EN
      gap_q    <= '0;
      gap_cnt  <= '0;
`endif
    end else begin
      bs_q   <= 1'b0;
      done_q <= 1'b0;
      // Wraps to zero on each bit_end, so every bit restarts its own count.
      if (tick) tick_cnt <= tick_cnt + 1'b1;

      if (ctl.abort && state != ST_IDLE) begin
        state  <= ST_IDLE;
        txd_q  <= 1'b1;
        busy_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_ok) begin
              if (sel_found) begin
                data_q   <= tx_data;
                pen_q    <= parity_en;
                peven_q  <= parity_even;
                two_q    <= two_stopbits;
`ifdef UART_PATTERN_TX_GAP_EN
                gap_q    <= gap_bits;
`endif
                pend_q   <= byte_mask & ~sel_oh;
                shreg    <= sel_byte;
                par_q    <= sel_par;
                tick_cnt <= '0;
                state    <= ST_START;
                txd_q    <= 1'b0;
                busy_q   <= 1'b1;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          ST_START: begin
            if (bit_end) begin
              state   <= ST_DATA;
              txd_q   <= shreg[0];
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            if (bit_end) begin
              if (bit_cnt == 3'd7) begin
                state <= pen_q ? ST_PARITY : ST_STOP1;
                txd_q <= pen_q ? par_q : 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= shreg >> 1;
                txd_q   <= shreg[1];
              end
            end
          end
          ST_PARITY: begin
            if (bit_end) begin
              state <= ST_STOP1;
              txd_q <= 1'b1;
            end
          end
          ST_STOP1: begin
            if (bit_end) begin
              state <= two_q ? ST_STOP2 : ST_NEXT;
              bs_q  <= !two_q;
            end
          end
          ST_STOP2: begin
            if (bit_end) begin
              state <= ST_NEXT;
              bs_q  <= 1'b1;
            end
          end
          ST_NEXT: begin
            tick_cnt <= '0;
            if (sel_found) begin
              pend_q <= pend_q & ~sel_oh;
              shreg  <= sel_byte;
              par_q  <= sel_par;
`ifdef UART_PATTERN_TX_GAP_EN
              if (gap_q != 4'd0) begin
                state   <= ST_GAP;
                gap_cnt <= '0;
              end else begin
                state <= ST_START;
                txd_q <= 1'b0;
              end
`else
              state <= ST_START;
              txd_q <= 1'b0;
`endif
            end else begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
`ifdef UART_PATTERN_TX_GAP_EN
          ST_GAP: begin
            if (bit_end) begin
              if (gap_cnt == gap_q - 4'd1) begin
                state <= ST_START;
                txd_q <= 1'b0;
              end else begin
                gap_cnt <= gap_cnt + 4'd1;
              end
            end
          end
`endif
          default: begin
            state  <= ST_IDLE;
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign txd           = txd_q;
  assign ctl.busy      = busy_q;
  assign ctl.byte_sent = bs_q;
  assign ctl.done      = done_q;

endmodule

// File: tb/tb_uart_pattern_tx.sv
// tb_uart_pattern_tx
//   Self-checking bench for uart_pattern_tx: a cycle-exact single-frame
//   sequence, a table of pattern vectors plus random patterns decoded by a
//   behavioural UART receiver, and hand-written abort/reset/start corners.
module tb_uart_pattern_tx;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] baud_inc;
  logic [63:0] tx_data;
  logic [7:0]  byte_mask;
  logic        parity_en, parity_even, two_stopbits;
  logic        txd;
`ifdef UART_PATTERN_TX_GAP_EN
  logic [3:0]  gap_bits = 4'd0;
`endif

  uart_pattern_tx_if ctl ();

  uart_pattern_tx #(.NBYTES(8), .INC_W(16)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .baud_inc     (baud_inc),
    .tx_data      (tx_data),
    .byte_mask    (byte_mask),
    .parity_en    (parity_en),
    .parity_even  (parity_even),
    .two_stopbits (two_stopbits),
`ifdef UART_PATTERN_TX_GAP_EN
    .gap_bits     (gap_bits),
`endif
    .ctl          (ctl.slave),
    .txd          (txd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int bs_cnt = 0, done_cnt = 0, busy_seen = 0;

  // Status pulses counted shortly after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (ctl.byte_sent === 1'b1) bs_cnt++;
    if (ctl.done === 1'b1) done_cnt++;
    if (ctl.busy === 1'b1) busy_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Reference frame: start 0, 8 data bits LSB first, optional parity, stops.
  function automatic int frame_bits(input logic [7:0] b, input bit pen, input bit peven,
                                    input bit two, output logic [11:0] bits);
    int k;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    k = 9;
    if (pen) begin
      bits[k] = peven ? (^b) : ~(^b);
      k++;
    end
    bits[k] = 1'b1;
    k++;
    if (two) begin
      bits[k] = 1'b1;
      k++;
    end
    return k;
  endfunction

  task automatic run_pattern(input string tag, input logic [7:0] mask, input logic [63:0] data,
                             input bit pen, input bit peven, input bit two,
                             input logic [15:0] inc, input int exp_n, input bit poke);
    int p, n, waited;
    logic [7:0]  q[$];
    logic [11:0] eb, rb;
    p = 8 * (65536 / int'(inc));
    for (int i = 0; i < 8; i++) if (mask[i]) q.push_back(data[8*i +: 8]);
    @(negedge clk);
    baud_inc = inc; tx_data = data; byte_mask = mask;
    parity_en = pen; parity_even = peven; two_stopbits = two;
    ctl.start = 1'b1; bs_cnt = 0; done_cnt = 0;
    @(negedge clk);
    ctl.start = 1'b0;
    foreach (q[f]) begin
      n = frame_bits(q[f], pen, peven, two, eb);
      waited = 0;
      while (txd !== 1'b0 && waited < 30 * p) begin
        @(negedge clk);
        waited++;
      end
      if (txd !== 1'b0) begin
        chk({tag, " start_timeout"}, 64'(txd), 64'd0);
        return;
      end
      rb = '0;
      repeat (p / 2) @(negedge clk);
      rb[0] = txd;
      for (int k = 1; k < n; k++) begin
        if (poke && f == 0 && k == 3) begin
          ctl.start = 1'b1; tx_data = ~data; byte_mask = 8'hFF;
          parity_en = ~pen; two_stopbits = ~two;
        end
        repeat (p) begin
          @(negedge clk);
          ctl.start = 1'b0;
        end
        rb[k] = txd;
      end
      chk($sformatf("%s frame%0d", tag, f), 64'(rb), 64'(eb));
    end
    waited = 0;
    while (ctl.busy === 1'b1 && waited < 4 * p) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    chk({tag, " busy_end"}, 64'(ctl.busy), 64'd0);
    chk({tag, " byte_sent_count"}, 64'(bs_cnt), 64'(exp_n));
    chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
  endtask

  // Cycle-exact single byte 0x55, start sampled at the edge ending cycle 0.
  task automatic exact_wave();
    int bad = 0, bs_at = -1, dn_at = -1;
    logic b1 = 1'b0, b161 = 1'b0, b162 = 1'b1;
    logic [7:0] d = 8'h55;
    logic e;
    @(negedge clk);
    baud_inc = 16'h8000; byte_mask = 8'h01; tx_data = 64'h55;
    parity_en = 1'b0; parity_even = 1'b0; two_stopbits = 1'b0; ctl.start = 1'b1;
    for (int c = 1; c <= 163; c++) begin
      @(negedge clk);
      ctl.start = 1'b0;
      if (c <= 16) e = 1'b0;
      else if (c <= 144) e = d[(c - 17) / 16];
      else e = 1'b1;
      if (c <= 162 && txd !== e) bad++;
      if (ctl.byte_sent === 1'b1 && bs_at < 0) bs_at = c;
      if (ctl.done === 1'b1 && dn_at < 0) dn_at = c;
      if (c == 1) b1 = ctl.busy;
      if (c == 161) b161 = ctl.busy;
      if (c == 162) b162 = ctl.busy;
    end
    chk("exact txd_mismatch_cycles", 64'(bad), 64'd0);
    chk("exact byte_sent_cycle", 64'(bs_at), 64'd161);
    chk("exact done_cycle", 64'(dn_at), 64'd162);
    chk("exact busy_c1", 64'(b1), 64'd1);
    chk("exact busy_c161", 64'(b161), 64'd1);
    chk("exact busy_c162", 64'(b162), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  mask;
    logic [63:0] data;
    bit          pen;
    bit          peven;
    bit          two;
    logic [15:0] inc;
    int          n;
    bit          poke;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'h01, 64'h0000_0000_0000_0055,       1'b0, 1'b0, 1'b0, 16'h8000, 1, 1'b0};
    tbl[1] = '{8'h05, 64'h0000_0000_00FF_0000,       1'b1, 1'b1, 1'b0, 16'h8000, 2, 1'b1};
    tbl[2] = '{8'h80, 64'hA500_0000_0000_0011,       1'b0, 1'b0, 1'b0, 16'h8000, 1, 1'b0};
    tbl[3] = '{8'h07, 64'h0000_0000_0056_3412,       1'b1, 1'b0, 1'b1, 16'h4000, 3, 1'b0};
    tbl[4] = '{8'hFF, 64'h0123_4567_89AB_CDEF,       1'b1, 1'b0, 1'b1, 16'h8000, 8, 1'b0};
    tbl[5] = '{8'h5A, 64'hDEAD_BEEF_CAFE_F00D,       1'b0, 1'b0, 1'b1, 16'h8000, 4, 1'b0};

    reset_i = 1'b0; baud_inc = 16'h8000; tx_data = '0; byte_mask = '0;
    parity_en = 1'b0; parity_even = 1'b0; two_stopbits = 1'b0;
    ctl.start = 1'b0; ctl.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset txd", 64'(txd), 64'd1);
    chk("reset busy", 64'(ctl.busy), 64'd0);
    chk("reset byte_sent", 64'(ctl.byte_sent), 64'd0);
    chk("reset done", 64'(ctl.done), 64'd0);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);

    exact_wave();

    for (int i = 0; i < 6; i++)
      run_pattern($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].data, tbl[i].pen,
                  tbl[i].peven, tbl[i].two, tbl[i].inc, tbl[i].n, tbl[i].poke);

    for (int r = 0; r < 8; r++) begin
      logic [7:0]  m;
      logic [63:0] d;
      m = 8'($urandom_range(1, 255));
      d = {$urandom(), $urandom()};
      run_pattern($sformatf("rnd%0d", r), m, d, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h4000, $countones(m), 1'b0);
    end

    // Empty mask: immediate done, never busy.
    @(negedge clk);
    byte_mask = 8'h00; ctl.start = 1'b1; done_cnt = 0; busy_seen = 0;
    @(negedge clk);
    ctl.start = 1'b0;
    chk("mask0 done", 64'(ctl.done), 64'd1);
    chk("mask0 busy", 64'(ctl.busy), 64'd0);
    chk("mask0 txd", 64'(txd), 64'd1);
    @(negedge clk);
    chk("mask0 done_cleared", 64'(ctl.done), 64'd0);
    repeat (5) @(negedge clk);
    chk("mask0 busy_seen", 64'(busy_seen), 64'd0);

    // Abort mid-frame at cycle 50, then a fresh start at cycle 60.
    @(negedge clk);
    baud_inc = 16'h8000; byte_mask = 8'h01; tx_data = 64'h0;
    parity_en = 1'b0; two_stopbits = 1'b0; ctl.start = 1'b1; bs_cnt = 0; done_cnt = 0;
    @(negedge clk);
    ctl.start = 1'b0;
    repeat (49) @(negedge clk);
    chk("abort pre_txd", 64'(txd), 64'd0);
    ctl.abort = 1'b1;
    @(negedge clk);
    ctl.abort = 1'b0;
    chk("abort txd", 64'(txd), 64'd1);
    chk("abort busy", 64'(ctl.busy), 64'd0);
    repeat (8) @(negedge clk);
    chk("abort no_done", 64'(done_cnt), 64'd0);
    chk("abort no_byte_sent", 64'(bs_cnt), 64'd0);
    run_pattern("after_abort", 8'h01, 64'h96, 1'b0, 1'b0, 1'b0, 16'h8000, 1, 1'b0);

    // start+abort together in IDLE: start discarded.
    @(negedge clk);
    byte_mask = 8'h01; ctl.start = 1'b1; ctl.abort = 1'b1; busy_seen = 0; done_cnt = 0;
    @(negedge clk);
    ctl.start = 1'b0; ctl.abort = 1'b0;
    chk("sa_idle busy", 64'(ctl.busy), 64'd0);
    chk("sa_idle txd", 64'(txd), 64'd1);
    repeat (20) @(negedge clk);
    chk("sa_idle busy_seen", 64'(busy_seen), 64'd0);
    chk("sa_idle done", 64'(done_cnt), 64'd0);

    // start+abort together while busy: aborts, no restart.
    @(negedge clk);
    byte_mask = 8'h03; tx_data = 64'h00; ctl.start = 1'b1; done_cnt = 0;
    @(negedge clk);
    ctl.start = 1'b0;
    repeat (30) @(negedge clk);
    ctl.start = 1'b1; ctl.abort = 1'b1;
    @(negedge clk);
    ctl.start = 1'b0; ctl.abort = 1'b0;
    chk("sa_busy busy", 64'(ctl.busy), 64'd0);
    chk("sa_busy txd", 64'(txd), 64'd1);
    busy_seen = 0;
    repeat (40) @(negedge clk);
    chk("sa_busy busy_seen", 64'(busy_seen), 64'd0);
    chk("sa_busy done", 64'(done_cnt), 64'd0);

    // baud_inc=0 stalls in the start bit until aborted.
    @(negedge clk);
    baud_inc = 16'h0000; byte_mask = 8'h01; ctl.start = 1'b1;
    @(negedge clk);
    ctl.start = 1'b0;
    repeat (100) @(negedge clk);
    chk("stall busy", 64'(ctl.busy), 64'd1);
    chk("stall txd", 64'(txd), 64'd0);
    ctl.abort = 1'b1;
    @(negedge clk);
    ctl.abort = 1'b0;
    chk("stall abort_busy", 64'(ctl.busy), 64'd0);

    // Reset mid-frame truncates immediately.
    @(negedge clk);
    baud_inc = 16'h8000; tx_data = 64'h00; ctl.start = 1'b1;
    @(negedge clk);
    ctl.start = 1'b0;
    repeat (40) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    chk("midreset txd", 64'(txd), 64'd1);
    chk("midreset busy", 64'(ctl.busy), 64'd0);
    done_cnt = 0; busy_seen = 0;
    repeat (20) @(negedge clk);
    chk("midreset done", 64'(done_cnt), 64'd0);
    chk("midreset busy_seen", 64'(busy_seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
